picaso_reduce_seq: RTL and testbench



---
 rtl/picaso_reduce_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_picaso_reduce_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picaso_reduce_seq.sv
// picaso_reduce_seq: sequences a multi-level binary-tree fold-and-accumulate
// reduction over a PiCaSO block array by driving its broadcast control bus.
// Each tree level takes one CONF cycle and then width+DATAPATH_LAT STREAM cycles.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, levels, width, srcAddr   run request and its operands (sampled in IDLE)
//   abort                 terminates a run in CONF/STREAM
//   busy, done, err       status: not idle / normal completion pulse / rejected start pulse
//   netLevel, netConfLoad, netCaptureEn          fold network control
//   aluConf, aluConfLoad, aluEn, aluReset        ALU control
//   opmuxConf, opmuxConfLoad, opmuxEn            operand mux control
//   saveAluOut, addrA, addrB                     register-file read/write control
// All outputs are registered.
module picaso_reduce_seq #(
  parameter int unsigned MAX_NET_LEVEL      = 3,
  parameter int unsigned NET_LEVEL_WIDTH    = 2,
  parameter int unsigned REGFILE_ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH          = 6,
  parameter int unsigned DATAPATH_LAT       = 2,
  parameter int unsigned ALU_OP_WIDTH       = 4,
  parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD_CONF = 4'd1,
  parameter int unsigned OPMUX_CONF_WIDTH   = 4,
  parameter logic [OPMUX_CONF_WIDTH-1:0] OPMUX_FOLD_CONF = 4'd2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NET_LEVEL_WIDTH:0]      levels,
  input  logic [CNT_WIDTH-1:0]          width,
  input  logic [REGFILE_ADDR_WIDTH-1:0] srcAddr,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [NET_LEVEL_WIDTH-1:0]    netLevel,
  output logic                          netConfLoad,
  output logic                          netCaptureEn,
  output logic [ALU_OP_WIDTH-1:0]       aluConf,
  output logic                          aluConfLoad,
  output logic                          aluEn,
  output logic                          aluReset,
  output logic [OPMUX_CONF_WIDTH-1:0]   opmuxConf,
  output logic                          opmuxConfLoad,
  output logic                          opmuxEn,
  output logic                          saveAluOut,
  output logic [REGFILE_ADDR_WIDTH-1:0] addrA,
  output logic [REGFILE_ADDR_WIDTH-1:0] addrB
);

  localparam int unsigned LVL_W = NET_LEVEL_WIDTH + 1;
  localparam int unsigned RW    = REGFILE_ADDR_WIDTH;
  // Stream counter must reach width_max + DATAPATH_LAT - 1.
  localparam int unsigned K_W   = $clog2((2 ** CNT_WIDTH) + DATAPATH_LAT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONF   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } stateT;

  stateT                state;
  logic [LVL_W-1:0]     lvl;
  logic [K_W-1:0]       kCnt;
  logic [LVL_W-1:0]     levelsQ;
  logic [CNT_WIDTH-1:0] widthQ;
  logic [RW-1:0]        srcQ;

  // Request validation for a start seen in IDLE.
  logic startBad;
  assign startBad = (levels == '0) || (levels > LVL_W'(MAX_NET_LEVEL)) || (width == '0);

  // Stream-address view of the following k (outputs are registered one cycle ahead).
  logic [K_W-1:0] kInc;
  logic [K_W-1:0] lastK;
  logic [K_W-1:0] widthM1;
  logic [K_W-1:0] kClamp;
  logic           nextSave;
  logic [RW-1:0]  nextAddrA;
  logic [RW-1:0]  nextAddrB;

  assign kInc      = kCnt + K_W'(1);
  assign widthM1   = K_W'(widthQ) - K_W'(1);
  assign lastK     = K_W'(widthQ) + K_W'(DATAPATH_LAT - 1);
  // addrA stops advancing once the last operand bit has been presented.
  assign kClamp    = (kInc > widthM1) ? widthM1 : kInc;
  assign nextSave  = (kInc >= K_W'(DATAPATH_LAT));
  assign nextAddrA = srcQ + RW'(kClamp);
  // Write-back trails the read address by the datapath latency.
  assign nextAddrB = nextSave ? (srcQ + RW'(kInc - K_W'(DATAPATH_LAT))) : srcQ;

  // State machine with registered control outputs computed for the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      lvl           <= '0;
      kCnt          <= '0;
      levelsQ       <= '0;
      widthQ        <= '0;
      srcQ          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      netLevel      <= '0;
      netConfLoad   <= 1'b0;
      netCaptureEn  <= 1'b0;
      aluConf       <= '0;
      aluConfLoad   <= 1'b0;
      aluEn         <= 1'b0;
      aluReset      <= 1'b0;
      opmuxConf     <= '0;
      opmuxConfLoad <= 1'b0;
      opmuxEn       <= 1'b0;
      saveAluOut    <= 1'b0;
      addrA         <= '0;
      addrB         <= '0;
    end else begin
      // Every control output idles low unless the branch below drives it.
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      netLevel      <= '0;
      netConfLoad   <= 1'b0;
      netCaptureEn  <= 1'b0;
      aluConf       <= '0;
      aluConfLoad   <= 1'b0;
      aluEn         <= 1'b0;
      aluReset      <= 1'b0;
      opmuxConf     <= '0;
      opmuxConfLoad <= 1'b0;
      opmuxEn       <= 1'b0;
      saveAluOut    <= 1'b0;
      addrA         <= '0;
      addrB         <= '0;

      case (state)
        IDLE: begin
          // abort is ignored here, so start+abort still launches a run.
          if (start) begin
            if (startBad) begin
              err <= 1'b1;
            end else begin
              levelsQ       <= levels;
              widthQ        <= width;
              srcQ          <= srcAddr;
              lvl           <= '0;
              state         <= CONF;
              busy          <= 1'b1;
              netConfLoad   <= 1'b1;
              aluConfLoad   <= 1'b1;
              aluConf       <= ALU_ADD_CONF;
              aluReset      <= 1'b1;
              opmuxConfLoad <= 1'b1;
              opmuxConf     <= OPMUX_FOLD_CONF;
            end
          end
        end

        CONF: begin
          if (abort) begin
            state <= IDLE;
          end else begin
            // First stream cycle: k=0 reads and nominally writes at the base address.
            state        <= STREAM;
            kCnt         <= '0;
            busy         <= 1'b1;
            netLevel     <= NET_LEVEL_WIDTH'(lvl);
            netCaptureEn <= 1'b1;
            opmuxEn      <= 1'b1;
            aluEn        <= 1'b1;
            // Configuration words stay presented while their enables are active.
            aluConf      <= ALU_ADD_CONF;
            opmuxConf    <= OPMUX_FOLD_CONF;
            addrA        <= srcQ;
            addrB        <= srcQ;
          end
        end

        STREAM: begin
          if (abort) begin
            state <= IDLE;
          end else if (kCnt == lastK) begin
            busy <= 1'b1;
            if (lvl == (levelsQ - LVL_W'(1))) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              lvl           <= lvl + LVL_W'(1);
              state         <= CONF;
              netLevel      <= NET_LEVEL_WIDTH'(lvl + LVL_W'(1));
              netConfLoad   <= 1'b1;
              aluConfLoad   <= 1'b1;
              aluConf       <= ALU_ADD_CONF;
              aluReset      <= 1'b1;
              opmuxConfLoad <= 1'b1;
              opmuxConf     <= OPMUX_FOLD_CONF;
            end
          end else begin
            kCnt         <= kInc;
            busy         <= 1'b1;
            netLevel     <= NET_LEVEL_WIDTH'(lvl);
            netCaptureEn <= 1'b1;
            opmuxEn      <= 1'b1;
            aluEn        <= 1'b1;
            aluConf      <= ALU_ADD_CONF;
            opmuxConf    <= OPMUX_FOLD_CONF;
            saveAluOut   <= nextSave;
            addrA        <= nextAddrA;
            addrB        <= nextAddrB;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picaso_reduce_seq.sv
// Scoreboard bench for picaso_reduce_seq: stimulus pushes the expected output
// vector of every upcoming cycle; a negedge monitor pops and compares.
module tb_picaso_reduce_seq;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] levels;
  logic [5:0] width;
  logic [9:0] srcAddr;
  logic       abort;
  logic       busy, done, err;
  logic [1:0] netLevel;
  logic       netConfLoad, netCaptureEn;
  logic [3:0] aluConf;
  logic       aluConfLoad, aluEn, aluReset;
  logic [3:0] opmuxConf;
  logic       opmuxConfLoad, opmuxEn, saveAluOut;
  logic [9:0] addrA, addrB;

  picaso_reduce_seq dut (
    .clk(clk), .reset(reset), .start(start), .levels(levels), .width(width),
    .srcAddr(srcAddr), .abort(abort), .busy(busy), .done(done), .err(err),
    .netLevel(netLevel), .netConfLoad(netConfLoad), .netCaptureEn(netCaptureEn),
    .aluConf(aluConf), .aluConfLoad(aluConfLoad), .aluEn(aluEn), .aluReset(aluReset),
    .opmuxConf(opmuxConf), .opmuxConfLoad(opmuxConfLoad), .opmuxEn(opmuxEn),
    .saveAluOut(saveAluOut), .addrA(addrA), .addrB(addrB)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] netLevel;
    logic       netConfLoad;
    logic       netCaptureEn;
    logic [3:0] aluConf;
    logic       aluConfLoad;
    logic       aluEn;
    logic       aluReset;
    logic [3:0] opmuxConf;
    logic       opmuxConfLoad;
    logic       opmuxEn;
    logic       saveAluOut;
    logic [9:0] addrA;
    logic [9:0] addrB;
  } outVec;

  typedef struct {
    int    cyc;
    outVec v;
  } expEntry;

  expEntry expQ[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  outVec actual;
  assign actual = '{busy, done, err, netLevel, netConfLoad, netCaptureEn, aluConf,
                    aluConfLoad, aluEn, aluReset, opmuxConf, opmuxConfLoad, opmuxEn,
                    saveAluOut, addrA, addrB};

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic outVec zeroVec();
    outVec v;
    v = '0;
    return v;
  endfunction

  function automatic outVec confVec(input int l);
    outVec v;
    v = '0;
    v.busy = 1'b1;
    v.netLevel = 2'(l);
    v.netConfLoad = 1'b1;
    v.aluConfLoad = 1'b1;
    v.aluConf = 4'd1;
    v.aluReset = 1'b1;
    v.opmuxConfLoad = 1'b1;
    v.opmuxConf = 4'd2;
    return v;
  endfunction

  function automatic outVec streamVec(input int l, input int k, input int w, input int src);
    outVec v;
    int rd;
    v = '0;
    v.busy = 1'b1;
    v.netLevel = 2'(l);
    v.netCaptureEn = 1'b1;
    v.opmuxEn = 1'b1;
    v.aluEn = 1'b1;
    v.aluConf = 4'd1;
    v.opmuxConf = 4'd2;
    rd = (k < w) ? k : (w - 1);
    v.addrA = 10'((src + rd) % 1024);
    if (k >= LAT) begin
      v.saveAluOut = 1'b1;
      v.addrB = 10'((src + k - LAT) % 1024);
    end else begin
      v.addrB = 10'(src);
    end
    return v;
  endfunction

  function automatic outVec doneVec();
    outVec v;
    v = '0;
    v.busy = 1'b1;
    v.done = 1'b1;
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      expEntry e;
      e = expQ.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL stale_expectation cycle=%0d actual=none required_cycle=%0d", cyc, e.cyc);
      end else if (actual !== e.v) begin
        failures++;
        $display("FAIL outputs cycle=%0d actual=%h required=%h (busy %0b/%0b done %0b/%0b err %0b/%0b save %0b/%0b addrA %0d/%0d addrB %0d/%0d netLevel %0d/%0d)",
                 cyc, actual, e.v, actual.busy, e.v.busy, actual.done, e.v.done,
                 actual.err, e.v.err, actual.saveAluOut, e.v.saveAluOut,
                 actual.addrA, e.v.addrA, actual.addrB, e.v.addrB,
                 actual.netLevel, e.v.netLevel);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expectNext(input outVec v);
    expEntry e;
    e.cyc = cyc + 1;
    e.v = v;
    expQ.push_back(e);
  endtask

  task automatic resetCycle();
    reset = 1'b1;
    start = 1'($urandom % 2);
    levels = 3'd1;
    width = 6'd1;
    srcAddr = 10'($urandom);
    abort = 1'b0;
    expectNext(zeroVec());
    step();
  endtask

  // One idle cycle; doStart must only be used with an invalid request.
  task automatic idleCycle(input bit doStart, input int lv, input int w, input int src);
    outVec v;
    reset = 1'b0;
    start = doStart;
    levels = 3'(lv);
    width = 6'(w);
    srcAddr = 10'(src);
    abort = 1'($urandom % 2);
    v = zeroVec();
    v.err = doStart && (lv == 0 || lv > 3 || w == 0);
    expectNext(v);
    step();
  endtask

  // A full run. cutAt >= 0 is the trace index (CONF/STREAM) during which abort or reset is driven.
  task automatic doRun(input int lv, input int w, input int src, input int cutAt, input bit useReset);
    outVec tr[$];
    for (int l = 0; l < lv; l++) begin
      tr.push_back(confVec(l));
      for (int k = 0; k < w + LAT; k++) tr.push_back(streamVec(l, k, w, src));
    end
    tr.push_back(doneVec());
    if (cutAt >= 0) begin
      while (tr.size() > cutAt + 1) void'(tr.pop_back());
    end
    tr.push_back(zeroVec());

    reset = 1'b0;
    start = 1'b1;
    levels = 3'(lv);
    width = 6'(w);
    srcAddr = 10'(src);
    abort = 1'($urandom % 2);
    expectNext(tr[0]);
    step();
    for (int j = 1; j < tr.size(); j++) begin
      // Requests while busy carry junk operands that must be ignored.
      reset = 1'b0;
      abort = 1'b0;
      start = 1'($urandom % 2);
      levels = 3'($urandom);
      width = 6'($urandom);
      srcAddr = 10'($urandom);
      if (cutAt >= 0 && j == cutAt + 1) begin
        if (useReset) reset = 1'b1;
        else abort = 1'b1;
      end else if (cutAt < 0 && j == tr.size() - 1) begin
        abort = 1'($urandom % 2);
      end
      expectNext(tr[j]);
      step();
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    levels = '0;
    width = '0;
    srcAddr = '0;
    abort = 1'b0;
    resetCycle();
    resetCycle();
    idleCycle(1'b0, 0, 0, 0);
    idleCycle(1'b0, 0, 0, 0);

    // Nominal three-level run.
    doRun(3, 8, 100, -1, 1'b0);
    idleCycle(1'b0, 0, 0, 0);

    // Rejected requests.
    idleCycle(1'b1, 3, 0, 5);
    idleCycle(1'b1, 4, 8, 5);
    idleCycle(1'b1, 0, 8, 5);
    idleCycle(1'b1, 7, 3, 5);
    idleCycle(1'b0, 0, 0, 0);

    // Address wrap.
    doRun(1, 8, 1020, -1, 1'b0);
    doRun(2, 5, 1022, -1, 1'b0);

    // Abort in level-1 STREAM (k=3), then the same cut via reset.
    doRun(3, 8, 100, 15, 1'b0);
    doRun(3, 8, 100, 15, 1'b1);
    idleCycle(1'b0, 0, 0, 0);
    // Abort in CONF.
    doRun(2, 4, 300, 0, 1'b0);

    // Single level minimal width, back-to-back with the next run.
    doRun(1, 1, 42, -1, 1'b0);
    doRun(1, 1, 1023, -1, 1'b0);
    doRun(3, 63, 999, -1, 1'b0);

    // Randomized runs with occasional cuts and idle gaps.
    for (int r = 0; r < 40; r++) begin
      int lv, w, src, cut, gap;
      lv = 1 + int'($urandom % 3);
      w = ($urandom % 8 == 0) ? 1 + int'($urandom % 63) : 1 + int'($urandom % 10);
      src = int'($urandom % 1024);
      cut = ($urandom % 4 == 0) ? int'($urandom % (lv * (w + LAT + 1))) : -1;
      doRun(lv, w, src, cut, 1'($urandom % 2));
      gap = int'($urandom % 3);
      for (int g = 0; g < gap; g++) begin
        if ($urandom % 2 == 0) idleCycle(1'b1, ($urandom % 2 == 0) ? 0 : 4 + int'($urandom % 4), int'($urandom % 8), int'($urandom % 1024));
        else idleCycle(1'b1, 1 + int'($urandom % 3), 0, int'($urandom % 1024));
      end
    end

    idleCycle(1'b0, 0, 0, 0);
    idleCycle(1'b0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
